// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the single write port (WE, RW, busW) of the 8 x 16-bit register
// file between two independent write requesters, for example ALU writeback
// and memory-load return. Each requester owns a one-entry holding buffer
// filled through a valid/ready handshake. A round-robin arbiter drains the
// buffers into registered write-port outputs, so the register file sees at
// most one clean write per cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/addr/data/ready    requester 0 handshake and payload
//   req1_valid/addr/data/ready    requester 1 handshake and payload
//   WE, RW, busW                  registered register-file write port
//   busy                          high while a buffer is full or WE is high
//
// Build option:
//   REG_ARB_FIXED_PRIO_EN  requester 0 always wins a contest and the
//                          round-robin pointer is not built. Undefined
//                          (default) gives round-robin arbitration.
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          WE,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          busy
);

  // Holding buffers, one entry per requester
  logic          r_full0;
  logic [AW-1:0] r_addr0;
  logic [DW-1:0] r_data0;
  logic          r_full1;
  logic [AW-1:0] r_addr1;
  logic [DW-1:0] r_data1;

  // Registered write port
  logic          r_we;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_busW;

  // Grant and handshake terms
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_accept0;
  logic          w_accept1;
  logic [AW-1:0] w_selAddr;
  logic [DW-1:0] w_selData;

`ifdef REG_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 only drains when requester 0 has nothing
  // waiting, so a continuously busy requester 0 starves requester 1.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_gnt0 = r_full0;
    w_gnt1 = r_full1 & ~r_full0;
  end
`else
  // Index of the requester granted most recently; 1 out of reset so that
  // requester 0 wins the very first contest.
  logic r_lastGnt;

  // Round-robin: a lone candidate always wins; with two candidates the one
  // that was not granted last takes the port.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_gnt0 = r_full0 & (~r_full1 | r_lastGnt);
    w_gnt1 = r_full1 & (~r_full0 | ~r_lastGnt);
  end

  // The pointer only moves when a grant actually issues, so idle cycles
  // keep the fairness history intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGnt <= 1'b1;
    end else if (w_gnt0 | w_gnt1) begin
      r_lastGnt <= w_gnt1;
    end
  end
`endif

  // A buffer is ready when it is empty or when it is draining this cycle;
  // the second term lets an uncontested requester stream one write per
  // cycle without a bubble.
  assign req0_ready = ~r_full0 | w_gnt0;
  assign req1_ready = ~r_full1 | w_gnt1;
  assign w_accept0  = req0_valid & req0_ready;
  assign w_accept1  = req1_valid & req1_ready;

  // At most one grant is active, so a simple select picks the winner.
  assign w_selAddr = w_gnt1 ? r_addr1 : r_addr0;
  assign w_selData = w_gnt1 ? r_data1 : r_data0;

  // Requester 0 buffer. A new acceptance takes precedence over the drain,
  // which is how the same-edge refill keeps full0 set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full0 <= 1'b0;
      r_addr0 <= '0;
      r_data0 <= '0;
    end else if (w_accept0) begin
      r_full0 <= 1'b1;
      r_addr0 <= req0_addr;
      r_data0 <= req0_data;
    end else if (w_gnt0) begin
      r_full0 <= 1'b0;
    end
  end

  // Requester 1 buffer, same behaviour as requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full1 <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else if (w_accept1) begin
      r_full1 <= 1'b1;
      r_addr1 <= req1_addr;
      r_data1 <= req1_data;
    end else if (w_gnt1) begin
      r_full1 <= 1'b0;
    end
  end

  // Write port register. RW and busW hold their last value when idle so
  // the register-file inputs do not toggle without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rw   <= '0;
      r_busW <= '0;
    end else if (w_gnt0 | w_gnt1) begin
      r_we   <= 1'b1;
      r_rw   <= w_selAddr;
      r_busW <= w_selData;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign WE   = r_we;
  assign RW   = r_rw;
  assign busW = r_busW;
  assign busy = r_full0 | r_full1 | r_we;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Self-checking bench for reg_write_arbiter. Expected register-file writes
// are pushed to a queue when requests are driven; a monitor pops and
// compares them whenever WE is seen high. Handshake and timing properties
// are checked inline by each scenario task. Build with
// REG_ARB_FIXED_PRIO_EN to add the fixed-priority scenario and switch the
// arbitration model.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          WE;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic          busy;

  int total;
  int bad;

  // Expected writes as {addr, data}, in issue order
  logic [AW+DW-1:0] expQ[$];

  // Register file contents as seen through the write port
  logic [DW-1:0] regFile [8];

  // Arbitration model: index of the requester granted most recently
  int modelLast;

  reg_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .WE        (WE),
    .RW        (RW),
    .busW      (busW),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner of a two-way contest under the current model state
  function automatic int firstWinner();
`ifdef REG_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (modelLast == 1) ? 0 : 1;
`endif
  endfunction

  task automatic pushOne(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    expQ.push_back({a, d});
    modelLast = idx;
  endtask

  task automatic pushPair(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    if (firstWinner() == 0) begin
      pushOne(0, a0, d0);
      pushOne(1, a1, d1);
    end else begin
      pushOne(1, a1, d1);
      pushOne(0, a0, d0);
    end
  endtask

  // Scoreboard monitor: every write seen on the port must be the next
  // expected one.
  task automatic monitorLoop();
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && WE) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_write got RW=%0d busW=%h, want no write", RW, busW);
        end else begin
          e = expQ.pop_front();
          if ({RW, busW} !== e) begin
            bad++;
            $display("[TB] FAIL write_order got RW=%0d busW=%h, want RW=%0d busW=%h",
                     RW, busW, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
        regFile[RW] = busW;
      end
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    tick();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain got pending=%0d, want 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic idleInputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    req0_data  = '0;
    req1_data  = '0;
  endtask

  // Pulse reset between edges; callers are positioned just after a rise.
  task automatic doReset();
    idleInputs();
    #2 rst = 1'b1;
    expQ.delete();
    modelLast = 1;
    #4 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({WE, RW, busW} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_port got %b/%0d/%h, want 0/0/0000", WE, RW, busW);
    end
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL reset_ready_busy got %b, want 110", {req0_ready, req1_ready, busy});
    end
    #19 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_addr  = 3'b000;
    req0_data  = 16'hff00;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_ready got %b, want 1", req0_ready);
    end
    pushOne(0, 3'b000, 16'hff00);
    tick();
    idleInputs();
    total++;
    if (WE !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_accepted got WE=%b busy=%b, want WE=0 busy=1", WE, busy);
    end
    tick();
    total++;
    if (WE !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_latency got WE=%b, want 1", WE);
    end
    tick();
    total++;
    if (WE !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_end got WE=%b busy=%b, want 0 0", WE, busy);
    end
    waitDrain("single");
  endtask

  task automatic test_contention();
    doReset();
    // First pair after reset: requester 0 wins
    req0_valid = 1'b1; req0_addr = 3'b001; req0_data = 16'h00ff;
    req1_valid = 1'b1; req1_addr = 3'b010; req1_data = 16'h1234;
    pushPair(3'b001, 16'h00ff, 3'b010, 16'h1234);
    tick();
    idleInputs();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL contend_ready1 got %b, want 10", {req0_ready, req1_ready});
    end
    tick();
    total++;
    if (req1_ready !== 1'b1 || WE !== 1'b1) begin
      bad++;
      $display("[TB] FAIL contend_loser_turn got ready1=%b WE=%b, want 1 1", req1_ready, WE);
    end
    waitDrain("contend1");

    // A lone requester 0 write moves the pointer, so the next pair
    // favours requester 1.
    req0_valid = 1'b1; req0_addr = 3'b011; req0_data = 16'h0f0f;
    pushOne(0, 3'b011, 16'h0f0f);
    tick();
    idleInputs();
    waitDrain("contend_mid");

    req0_valid = 1'b1; req0_addr = 3'b001; req0_data = 16'h4321;
    req1_valid = 1'b1; req1_addr = 3'b010; req1_data = 16'h8765;
    pushPair(3'b001, 16'h4321, 3'b010, 16'h8765);
    tick();
    idleInputs();
`ifndef REG_ARB_FIXED_PRIO_EN
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL contend_ready2 got %b, want 01", {req0_ready, req1_ready});
    end
`endif
    waitDrain("contend2");
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      req1_valid = 1'b1;
      req1_addr  = 3'b111;
      req1_data  = DW'(k);
      total++;
      if (req1_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_ready[%0d] got %b, want 1", k, req1_ready);
      end
      pushOne(1, 3'b111, DW'(k));
      tick();
      if (k >= 2) begin
        total++;
        if (WE !== 1'b1) begin
          bad++;
          $display("[TB] FAIL stream_we[%0d] got %b, want 1", k, WE);
        end
      end
    end
    idleInputs();
    tick();
    total++;
    if (WE !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stream_we_last got %b, want 1", WE);
    end
    tick();
    total++;
    if (WE !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stream_end got %b, want 0", WE);
    end
    waitDrain("stream");
  endtask

  task automatic test_collision();
    req0_valid = 1'b1; req0_addr = 3'b100; req0_data = 16'haaaa;
    req1_valid = 1'b1; req1_addr = 3'b100; req1_data = 16'h5555;
    pushPair(3'b100, 16'haaaa, 3'b100, 16'h5555);
    tick();
    idleInputs();
    waitDrain("collision");
    total++;
    if (regFile[4] !== 16'h5555) begin
      bad++;
      $display("[TB] FAIL collision_final got %h, want 5555", regFile[4]);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    req0_valid = 1'b1; req0_addr = 3'b101; req0_data = 16'hdead;
    req1_valid = 1'b1; req1_addr = 3'b110; req1_data = 16'hbeef;
    tick();
    idleInputs();
    tick();
    total++;
    if (WE !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_before got WE=%b busy=%b, want 1 1", WE, busy);
    end
    #2 rst = 1'b1;
    expQ.delete();
    modelLast = 1;
    #1;
    total++;
    if ({WE, busy, req0_ready, req1_ready} !== 4'b0011) begin
      bad++;
      $display("[TB] FAIL midrst_async got %b, want 0011", {WE, busy, req0_ready, req1_ready});
    end
    #3 rst = 1'b0;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (WE === 1'b1) writes++;
    end
    total++;
    if (writes !== 0) begin
      bad++;
      $display("[TB] FAIL midrst_replay got %0d writes, want 0", writes);
    end
  endtask

`ifdef REG_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_addr = 3'b001; req0_data = 16'ha000 + DW'(k);
      req1_valid = 1'b1; req1_addr = 3'b010; req1_data = 16'hb001;
      pushOne(0, 3'b001, 16'ha000 + DW'(k));
      if (k > 0) begin
        total++;
        if (req1_ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL fixed_ready1[%0d] got %b, want 0", k, req1_ready);
        end
      end
      tick();
    end
    idleInputs();
    total++;
    if (req1_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fixed_ready1_end got %b, want 0", req1_ready);
    end
    pushOne(1, 3'b010, 16'hb001);
    waitDrain("fixed");
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    modelLast = 1;
    for (int i = 0; i < 8; i++) regFile[i] = '0;
    rst = 1'b1;
    idleInputs();
    fork
      monitorLoop();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_collision();
    test_reset_mid();
`ifdef REG_ARB_FIXED_PRIO_EN
    doReset();
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
